// File: rtl/cnn_dma_read_sched.sv
// ---------------------------------------------------------------------------
// cnn_dma_read_sched
//
// Read-channel scheduler between the DMA PCIS AXI slave and the CNN result
// stream (output of the 64-to-512 width converter). AR requests are queued.
// Result beats are then streamed onto the R channel with the RID of the active
// burst, a per-burst RLAST and an OKAY response. R beats are also counted so
// that the block can flag CNN image boundaries.
//
// Ports
//   clock, reset          sole clock; synchronous active-high reset
//   ar_valid/ar_ready     AR handshake; ar_id, ar_len (ARLEN = beats-1)
//   res_valid/res_ready   result stream handshake; res_data
//   r_valid/r_ready       R handshake; r_id, r_data, r_resp (always OKAY), r_last
//   img_done              one-cycle pulse after the last beat of each image
//   img_count             completed images, wraps at 2^32
//   outstanding           queued ARs plus the active burst
// ---------------------------------------------------------------------------
module cnn_dma_read_sched #(
  parameter int ID_W          = 16,
  parameter int DATA_W        = 512,
  parameter int AR_DEPTH      = 4,    // power of two, 2..128
  parameter int BEATS_PER_IMG = 64    // at least 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ar_valid,
  output logic              ar_ready,
  input  logic [ID_W-1:0]   ar_id,
  input  logic [7:0]        ar_len,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [ID_W-1:0]   r_id,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              r_last,
  output logic              img_done,
  output logic [31:0]       img_count,
  output logic [7:0]        outstanding
);

  localparam int PTR_W = $clog2(AR_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = (BEATS_PER_IMG > 1) ? $clog2(BEATS_PER_IMG) : 1;

  localparam logic [CNT_W-1:0] Q_FULL  = CNT_W'(AR_DEPTH);
  localparam logic [BC_W-1:0]  BC_LAST = BC_W'(BEATS_PER_IMG - 1);

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [7:0]      len;
  } ar_entry_t;

  // AR queue storage and control
  ar_entry_t        q_mem [AR_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] q_cnt;
  logic [CNT_W-1:0] q_cnt_nxt;
  ar_entry_t        q_head;

  // Burst sequencing
  state_t           state;
  logic [ID_W-1:0]  cur_id;
  logic [7:0]       beats_left;
  logic [BC_W-1:0]  beat_cnt;
  logic             img_done_q;

  logic in_burst;
  logic push;
  logic pop;
  logic beat;
  logic burst_end;
  logic burst_nxt;

  assign q_head = q_mem[rd_ptr];

  // Full is judged from the registered count only, so a pop in the same
  // cycle never opens a slot early.
  assign ar_ready  = (q_cnt != Q_FULL) && !reset;
  assign push      = ar_valid && ar_ready;

  // The R channel is a combinational pass-through of the result stream while
  // a burst is active.
  assign in_burst  = (state == BURST) && !reset;
  assign r_valid   = in_burst && res_valid;
  assign res_ready = in_burst && r_ready;
  assign r_data    = res_data;
  assign r_id      = cur_id;
  assign r_resp    = 2'b00;
  assign r_last    = in_burst && (beats_left == 8'd0);
  assign img_done  = img_done_q && !reset;

  assign beat      = r_valid && r_ready;
  assign burst_end = beat && (beats_left == 8'd0);

  // Load the next burst from an idle state, or chain it straight after a last
  // beat so that back-to-back bursts have no bubble.
  assign pop       = (q_cnt != '0) && ((state == IDLE) || burst_end);
  assign burst_nxt = pop || ((state == BURST) && !burst_end);
  assign q_cnt_nxt = q_cnt + CNT_W'(push) - CNT_W'(pop);

  // NOTE: queue storage carries no reset; entries are only read after being
  // written, so only the pointers and count need clearing.
  always_ff @(posedge clock) begin
    if (push) q_mem[wr_ptr] <= '{id: ar_id, len: ar_len};
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_cnt       <= '0;
      cur_id      <= '0;
      beats_left  <= '0;
      beat_cnt    <= '0;
      img_count   <= '0;
      img_done_q  <= 1'b0;
      outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      q_cnt       <= q_cnt_nxt;
      outstanding <= 8'(q_cnt_nxt) + 8'(burst_nxt);

      case (state)
        IDLE: begin
          if (pop) begin
            cur_id     <= q_head.id;
            beats_left <= q_head.len;
            state      <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            if (beats_left != 8'd0) begin
              beats_left <= beats_left - 8'd1;
            end else if (pop) begin
              cur_id     <= q_head.id;
              beats_left <= q_head.len;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Image accounting runs on every R beat regardless of burst boundaries.
      img_done_q <= 1'b0;
      if (beat) begin
        if (beat_cnt == BC_LAST) begin
          beat_cnt   <= '0;
          img_count  <= img_count + 32'd1;
          img_done_q <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + BC_W'(1);
        end
      end
    end
  end

endmodule
